// File: rtl/jag_bus_resolver.sv
// rtl/jag_bus_resolver.sv - multi-driver shared bus resolver with keeper, decay and contention tracking
// Each bit resolves independently; lowest-index enabling driver wins on disagreement.

module jag_bus_resolver #(
    parameter int               WIDTH = 64,
    parameter int               NDRV  = 4,
    parameter logic [WIDTH-1:0] PULL  = '0,
    parameter int               DECAY = 8
) (
    input  logic                             clk_sys,
    input  logic                             reset,
    input  logic [NDRV*WIDTH-1:0]            drv_out,
    input  logic [NDRV*WIDTH-1:0]            drv_oe,
    input  logic                             clr_err,
    output logic [WIDTH-1:0]                 bus_in,
    output logic [WIDTH-1:0]                 bus_q,
    output logic [WIDTH-1:0]                 driven,
    output logic [WIDTH-1:0]                 err_mask,
    output logic [15:0]                      err_cnt,
    output logic [(NDRV > 1 ? $clog2(NDRV) : 1)-1:0] owner,
    output logic                             idle
);

    localparam int OW    = (NDRV > 1) ? $clog2(NDRV) : 1;
    localparam int FW    = (DECAY > 0) ? $clog2(DECAY + 1) : 1;
    localparam int DLAST = (DECAY > 0) ? DECAY - 1 : 0;
    localparam logic [FW-1:0] DEC_MAX  = FW'(DECAY);
    localparam logic [FW-1:0] DEC_LAST = FW'(DLAST);

    logic [WIDTH-1:0] keep_q, keep_d;
    logic [WIDTH-1:0] bus_q_d;
    logic [WIDTH-1:0] err_mask_q, err_mask_d;
    logic [15:0]      err_cnt_q, err_cnt_d;
    logic [FW-1:0]    float_cnt_q, float_cnt_d;

    logic [WIDTH-1:0] found;
    logic [WIDTH-1:0] val;
    logic [WIDTH-1:0] cont;
    logic [WIDTH-1:0] oe_k;
    logic [WIDTH-1:0] out_k;
    logic             own_found;
    logic             any_cont;

    // val tracks the first enabling driver per bit; any later enabler that
    // disagrees with it marks the bit contended.
    always_comb begin
        found     = '0;
        val       = '0;
        cont      = '0;
        oe_k      = '0;
        out_k     = '0;
        owner     = '0;
        own_found = 1'b0;
        for (int k = 0; k < NDRV; k++) begin
            oe_k  = drv_oe[k*WIDTH +: WIDTH];
            out_k = drv_out[k*WIDTH +: WIDTH];
            cont  = cont | (found & oe_k & (out_k ^ val));
            val   = (val & (found | ~oe_k)) | (out_k & oe_k & ~found);
            found = found | oe_k;
            if (!own_found && (|oe_k)) begin
                owner     = OW'(k);
                own_found = 1'b1;
            end
        end
    end

    assign driven   = found;
    assign idle     = ~(|found);
    assign bus_in   = (val & found) | (keep_q & ~found);
    assign any_cont = |cont;

    always_comb begin
        keep_d      = (keep_q & ~found) | (val & found);
        bus_q_d     = bus_in;
        float_cnt_d = float_cnt_q;
        err_mask_d  = err_mask_q | cont;
        err_cnt_d   = err_cnt_q;

        if (!idle) begin
            float_cnt_d = '0;
        end else if ((DECAY > 0) && (float_cnt_q < DEC_MAX)) begin
            float_cnt_d = float_cnt_q + 1'b1;
        end

        // Decay only fires on a fully idle cycle, so every bit is undriven here.
        if ((DECAY > 0) && idle && (float_cnt_q == DEC_LAST)) begin
            keep_d = PULL;
        end

        if (any_cont && (err_cnt_q != 16'hFFFF)) begin
            err_cnt_d = err_cnt_q + 16'd1;
        end

        if (clr_err) begin
            err_mask_d = '0;
            err_cnt_d  = '0;
        end
    end

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            keep_q      <= PULL;
            bus_q       <= PULL;
            err_mask_q  <= '0;
            err_cnt_q   <= '0;
            float_cnt_q <= '0;
        end else begin
            keep_q      <= keep_d;
            bus_q       <= bus_q_d;
            err_mask_q  <= err_mask_d;
            err_cnt_q   <= err_cnt_d;
            float_cnt_q <= float_cnt_d;
        end
    end

    assign err_mask = err_mask_q;
    assign err_cnt  = err_cnt_q;

endmodule

// File: tb/tb_jag_bus_resolver.sv
// tb/tb_jag_bus_resolver.sv - directed self-checking bench for jag_bus_resolver

module tb_jag_bus_resolver;

    localparam int W = 64;
    localparam int N = 4;

    logic           clk_sys;
    logic           reset;
    logic [N*W-1:0] drv_out;
    logic [N*W-1:0] drv_oe;
    logic           clr_err;
    logic [W-1:0]   bus_in;
    logic [W-1:0]   bus_q;
    logic [W-1:0]   driven;
    logic [W-1:0]   err_mask;
    logic [15:0]    err_cnt;
    logic [1:0]     owner;
    logic           idle;

    int tests;
    int fails;

    jag_bus_resolver #(
        .WIDTH(W),
        .NDRV (N),
        .PULL ('0),
        .DECAY(8)
    ) dut (
        .clk_sys (clk_sys),
        .reset   (reset),
        .drv_out (drv_out),
        .drv_oe  (drv_oe),
        .clr_err (clr_err),
        .bus_in  (bus_in),
        .bus_q   (bus_q),
        .driven  (driven),
        .err_mask(err_mask),
        .err_cnt (err_cnt),
        .owner   (owner),
        .idle    (idle)
    );

    initial clk_sys = 1'b0;
    always #5 clk_sys = ~clk_sys;

    task automatic tick();
        @(posedge clk_sys);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic set_drv(input int k, input logic [63:0] o, input logic [63:0] e);
        drv_out[k*W +: W] = o;
        drv_oe[k*W +: W]  = e;
    endtask

    task automatic clear_drv();
        drv_out = '0;
        drv_oe  = '0;
    endtask

    initial begin
        tests   = 0;
        fails   = 0;
        reset   = 1'b1;
        clr_err = 1'b0;
        clear_drv();
        tick();
        tick();
        reset = 1'b0;
        #1;
        chk("rst_bus_q", bus_q, 64'h0);
        chk("rst_err_mask", err_mask, 64'h0);
        chk("rst_err_cnt", {48'h0, err_cnt}, 64'h0);
        chk("rst_idle", {63'h0, idle}, 64'h1);
        chk("rst_bus_in", bus_in, 64'h0);
        chk("rst_owner", {62'h0, owner}, 64'h0);
        chk("rst_driven", driven, 64'h0);

        // single driver
        set_drv(2, 64'h0123456789ABCDEF, '1);
        #1;
        chk("single_bus_in", bus_in, 64'h0123456789ABCDEF);
        chk("single_owner", {62'h0, owner}, 64'h2);
        chk("single_driven", driven, 64'hFFFFFFFFFFFFFFFF);
        chk("single_idle", {63'h0, idle}, 64'h0);
        tick();
        chk("single_bus_q", bus_q, 64'h0123456789ABCDEF);
        chk("single_err_cnt", {48'h0, err_cnt}, 64'h0);

        // keeper then decay
        clear_drv();
        set_drv(0, '1, '1);
        tick();
        clear_drv();
        for (int i = 1; i <= 8; i++) begin
            #1;
            chk($sformatf("keep_idle%0d", i), bus_in, 64'hFFFFFFFFFFFFFFFF);
            tick();
        end
        chk("decay_bus_in", bus_in, 64'h0);
        chk("decay_bus_q_lag", bus_q, 64'hFFFFFFFFFFFFFFFF);
        tick();
        chk("decay_bus_q", bus_q, 64'h0);
        chk("decay_hold", bus_in, 64'h0);

        // contention on bit 5
        set_drv(0, 64'h20, 64'h20);
        set_drv(3, 64'h00, 64'h20);
        #1;
        chk("cont_bus_in", bus_in, 64'h20);
        chk("cont_owner", {62'h0, owner}, 64'h0);
        tick();
        tick();
        tick();
        chk("cont_err_mask", err_mask, 64'h20);
        chk("cont_err_cnt", {48'h0, err_cnt}, 64'h3);
        set_drv(3, 64'h20, 64'h20);
        tick();
        chk("agree_err_cnt", {48'h0, err_cnt}, 64'h3);
        chk("agree_err_mask", err_mask, 64'h20);

        // clear wins over contention in the same cycle
        set_drv(3, 64'h00, 64'h20);
        clr_err = 1'b1;
        tick();
        clr_err = 1'b0;
        set_drv(3, 64'h00, 64'h00);
        #1;
        chk("clr_err_mask", err_mask, 64'h0);
        chk("clr_err_cnt", {48'h0, err_cnt}, 64'h0);

        // saturation
        set_drv(3, 64'h00, 64'h20);
        repeat (65535) tick();
        chk("sat_reach", {48'h0, err_cnt}, 64'hFFFF);
        tick();
        tick();
        tick();
        chk("sat_hold", {48'h0, err_cnt}, 64'hFFFF);
        clr_err = 1'b1;
        clear_drv();
        tick();
        clr_err = 1'b0;
        chk("sat_clr", {48'h0, err_cnt}, 64'h0);

        // split ownership
        set_drv(1, 64'h00000000AAAAAAAA, 64'h00000000FFFFFFFF);
        set_drv(2, 64'h5555555500000000, 64'hFFFFFFFF00000000);
        #1;
        chk("split_bus_in", bus_in, 64'h55555555AAAAAAAA);
        chk("split_owner", {62'h0, owner}, 64'h1);
        tick();
        chk("split_err_cnt", {48'h0, err_cnt}, 64'h0);
        chk("split_err_mask", err_mask, 64'h0);

        // reset mid-operation
        clear_drv();
        set_drv(1, 64'h1, 64'h1);
        set_drv(2, 64'h0, 64'h1);
        tick();
        clear_drv();
        set_drv(0, 64'hDEADBEEFCAFEF00D, '1);
        tick();
        clear_drv();
        tick();
        tick();
        tick();
        chk("pre_rst_keep", bus_in, 64'hDEADBEEFCAFEF00D);
        chk("pre_rst_err_cnt", {48'h0, err_cnt}, 64'h1);
        reset = 1'b1;
        tick();
        chk("in_rst_bus_in", bus_in, 64'h0);
        reset = 1'b0;
        #1;
        chk("post_rst_bus_in", bus_in, 64'h0);
        chk("post_rst_bus_q", bus_q, 64'h0);
        chk("post_rst_err_cnt", {48'h0, err_cnt}, 64'h0);
        chk("post_rst_err_mask", err_mask, 64'h0);
        chk("post_rst_idle", {63'h0, idle}, 64'h1);
        repeat (9) tick();
        chk("post_rst_settled", bus_in, 64'h0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
